// File: rtl/sum_bin2bcd.sv
// sum_bin2bcd: sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// Converts the unsigned adder sum to DIGITS packed BCD digits, one input bit per clock.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   bin        in   W-bit binary value, sampled on acceptance (in_valid & in_ready)
//   in_valid   in   bin is valid
//   in_ready   out  converter idle and able to accept
//   bcd        out  packed BCD result, [3:0] units, [7:4] tens, [11:8] hundreds
//   out_valid  out  bcd holds a complete result
//   out_ready  in   consumer accepts the result
module sum_bin2bcd #(
   parameter int unsigned W      = 9,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [W-1:0]          bin,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e               r_state;
   state_e               w_state_next;
   logic [W-1:0]         r_sr;
   logic [W-1:0]         w_sr_next;
   logic [4*DIGITS-1:0]  r_work;
   logic [4*DIGITS-1:0]  w_work_next;
   logic [4*DIGITS-1:0]  w_adj;
   logic [4*DIGITS-1:0]  w_work_shifted;
   logic [CntW-1:0]      r_cnt;
   logic [CntW-1:0]      w_cnt_next;
   logic [4*DIGITS-1:0]  r_bcd;
   logic [4*DIGITS-1:0]  w_bcd_next;

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
         r_sr    <= '0;
         r_work  <= '0;
         r_cnt   <= '0;
         r_bcd   <= '0;
      end else begin
         r_state <= w_state_next;
         r_sr    <= w_sr_next;
         r_work  <= w_work_next;
         r_cnt   <= w_cnt_next;
         r_bcd   <= w_bcd_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (in_valid) w_state_next = StShift;
         StShift: if (r_cnt == LastCnt) w_state_next = StDone;
         StDone:  if (out_ready) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (r_state)
         StIdle:  in_ready  = 1'b1;
         StDone:  out_valid = 1'b1;
         default: ;
      endcase
   end

   assign bcd = r_bcd;

   // Add-3 correction, every digit judged on the pre-iteration value
   always_comb begin
      w_adj = r_work;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_work[4*d +: 4] >= 4'd5) begin
            w_adj[4*d +: 4] = r_work[4*d +: 4] + 4'd3;
         end
      end
   end

   // Shift {digits, binary} left; binary MSB enters the units LSB
   assign w_work_shifted = {w_adj[4*DIGITS-2:0], r_sr[W-1]};

   // Datapath next-state
   always_comb begin
      w_sr_next   = r_sr;
      w_work_next = r_work;
      w_cnt_next  = r_cnt;
      w_bcd_next  = r_bcd;
      unique case (r_state)
         StIdle: begin
            if (in_valid) begin
               w_sr_next   = bin;
               w_work_next = '0;
               w_cnt_next  = '0;
            end
         end
         StShift: begin
            w_work_next = w_work_shifted;
            w_sr_next   = {r_sr[W-2:0], 1'b0};
            w_cnt_next  = r_cnt + CntW'(1);
            // Result register is only written on the final iteration
            if (r_cnt == LastCnt) w_bcd_next = w_work_shifted;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/sum_bin2bcd.md
Name: sum_bin2bcd

Overview:
Sequential binary-to-BCD converter that sits directly downstream of the 8-bit adder and consumes its 9-bit unsigned sum (0..510). It runs the shift-and-add-3 (double-dabble) algorithm, one bit per clock, and produces three packed BCD digits for the display/decoder stage. A valid/ready handshake is used on both the input and output sides.

Parameters:
W, 9, width of the binary input; matches the adder sum width.
DIGITS, 3, number of BCD output digits. Requires 10^DIGITS > 2^W - 1; the defaults satisfy this.

Ports:
clk  input  1  sole clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
bin  input  W  binary sum from the adder, sampled only on acceptance.
in_valid  input  1  bin is valid.
in_ready  output  1  converter can accept; high only in IDLE.
bcd  output  4*DIGITS  packed BCD result; bits [3:0] are units, [7:4] tens, [11:8] hundreds.
out_valid  output  1  bcd holds a complete result.
out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset is synchronous, active-high, one clock, and has priority over everything else.
  - State goes to IDLE; the bit counter and all internal registers clear.
  - Outputs after reset: bcd=0, out_valid=0, in_ready=1.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch bin into the shift register, clear the BCD working register, set counter=0, go to SHIFT.
  - With in_valid=0, stay in IDLE.
- SHIFT, one iteration per edge:
  - First, every 4-bit digit of the working register that is >=5 gets +3; all digits are checked in parallel against the pre-iteration value.
  - Then {working BCD, shift register} shifts left by 1; the MSB of bin enters the BCD LSB.
  - Counter increments. After the W-th iteration (counter reaches W-1 on that edge), the result is copied to bcd and the state goes to DONE.
  - in_ready=0 throughout. in_valid is ignored and the value presented is not captured.
- DONE:
  - out_valid=1; bcd is held stable.
  - On an edge with out_ready=1, go to IDLE. out_valid drops and in_ready rises on the following cycle.
  - With out_ready=0, stay in DONE indefinitely (backpressure); bcd must not change.
- Latency: out_valid is high exactly W+0 edges after the acceptance edge, i.e. the first cycle after 9 SHIFT edges. Throughput is one conversion per W+2 cycles minimum.
- Output register behaviour:
  - bcd keeps its last result across IDLE; it is overwritten only at DONE entry.
  - bcd is never driven from the working register mid-conversion.
- Digits never exceed 9. Any digit nibble >9 at DONE is an error.
- Boundary values: bin=0 gives bcd=0x000. bin=510 gives 0x510, the maximum for W=9.
- Reset mid-operation: asserting rst in SHIFT or DONE aborts the conversion. There is no partial output: bcd=0 and out_valid=0 on the next cycle.
- Simultaneous rst and in_valid: rst wins and nothing is accepted.

Test Plan:
- Reset, then bin=9'd0 with in_valid pulsed for 1 cycle -> in_ready low for 10 cycles; out_valid rises 9 edges after acceptance with bcd=12'h000.
- bin=9'd255, then 9'd256, then 9'd510, each with out_ready=1 -> bcd=12'h255, 12'h256, 12'h510 respectively; in_ready returns 1 cycle after each DONE.
- bin=9'd9, then 9'd10, then 9'd99, then 9'd100 -> bcd=12'h009, 12'h010, 12'h099, 12'h100 (digit roll-over checks).
- bin=9'd375, out_ready held 0 for 20 cycles -> out_valid stays 1 and bcd=12'h375 is stable the whole time. Raise out_ready -> the next cycle shows out_valid=0, in_ready=1.
- Start bin=9'd480, assert rst at the 4th SHIFT edge -> the next cycle shows bcd=0, out_valid=0, in_ready=1. A new bin=9'd17 then yields bcd=12'h017.
- During a conversion of 9'd123, toggle in_valid with bin=9'd400 -> result is 12'h123. The 400 is accepted only once back in IDLE and yields 12'h400.
